// File: rtl/spi_modport.sv
// Loopback SPI pair: an internal mode-0, MSB-first master and slave exchange their shift
// registers through internal sclk/mosi/miso/ss_n nets. The transfer is sequenced from mclk.
module spi_modport #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  load_master,
    input  logic                  load_slave,
    input  logic                  read_master,
    input  logic                  read_slave,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in_master,
    input  logic [DATA_WIDTH-1:0] data_in_slave,
    output logic [DATA_WIDTH-1:0] data_out_master,
    output logic [DATA_WIDTH-1:0] data_out_slave
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam int CW  = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_bit_cnt;
    logic                  r_sclk;
    logic                  r_ss_n;
    logic                  r_master_smp;
    logic                  r_slave_smp;
    logic [DATA_WIDTH-1:0] r_master_sr;
    logic [DATA_WIDTH-1:0] r_slave_sr;
    logic [DATA_WIDTH-1:0] r_dout_master;
    logic [DATA_WIDTH-1:0] r_dout_slave;

    logic w_sclk;
    logic w_ss_n;
    logic w_mosi;
    logic w_miso;

    assign w_sclk = r_sclk;
    assign w_ss_n = r_ss_n;
    assign w_mosi = r_master_sr[MSB];
    assign w_miso = r_slave_sr[MSB];

    assign data_out_master = r_dout_master;
    assign data_out_slave  = r_dout_slave;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_sclk        <= 1'b0;
            r_ss_n        <= 1'b1;
            r_master_smp  <= 1'b0;
            r_slave_smp   <= 1'b0;
            r_master_sr   <= '0;
            r_slave_sr    <= '0;
            r_dout_master <= '0;
            r_dout_slave  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Reads sample the register before any same-cycle load lands.
                    if (read_master) r_dout_master <= r_master_sr;
                    if (read_slave)  r_dout_slave  <= r_slave_sr;
                    if (load_master) r_master_sr   <= data_in_master;
                    if (load_slave)  r_slave_sr    <= data_in_slave;
                    if (start) begin
                        r_state   <= XFER;
                        r_bit_cnt <= '0;
                        r_ss_n    <= 1'b0;
                        r_sclk    <= 1'b0;
                    end
                end
                XFER: begin
                    if (!w_sclk) begin
                        // Rising sclk: both ends sample the opposite MSB.
                        r_sclk       <= 1'b1;
                        r_master_smp <= w_miso;
                        if (!w_ss_n) r_slave_smp <= w_mosi;
                    end else begin
                        r_sclk      <= 1'b0;
                        r_master_sr <= (r_master_sr << 1) | DATA_WIDTH'(r_master_smp);
                        r_slave_sr  <= (r_slave_sr << 1) | DATA_WIDTH'(r_slave_smp);
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            r_state <= IDLE;
                            r_ss_n  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_modport.sv
// Directed bench for spi_modport: expected read-backs are queued when a transfer is
// launched and popped when the read result appears on data_out_*.
module tb_spi_modport;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic       load_master = 1'b0;
    logic       load_slave = 1'b0;
    logic       read_master = 1'b0;
    logic       read_slave = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in_master = '0;
    logic [7:0] data_in_slave = '0;
    logic [7:0] data_out_master;
    logic [7:0] data_out_slave;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_m_q[$];
    logic [7:0] exp_s_q[$];

    spi_modport #(.DATA_WIDTH(8)) dut (
        .mclk           (mclk),
        .reset          (reset),
        .load_master    (load_master),
        .load_slave     (load_slave),
        .read_master    (read_master),
        .read_slave     (read_slave),
        .start          (start),
        .data_in_master (data_in_master),
        .data_in_slave  (data_in_slave),
        .data_out_master(data_out_master),
        .data_out_slave (data_out_slave)
    );

    always #5 mclk = ~mclk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input logic [7:0] m, input logic [7:0] s);
        exp_m_q.push_back(m);
        exp_s_q.push_back(s);
    endtask

    // Read both sides; optionally load new values in the same cycle.
    task automatic do_read(input string tag, input bit ld = 1'b0,
                           input logic [7:0] m = 8'h00, input logic [7:0] s = 8'h00);
        logic [7:0] em;
        logic [7:0] es;
        read_master = 1'b1;
        read_slave  = 1'b1;
        if (ld) begin
            load_master = 1'b1; load_slave = 1'b1;
            data_in_master = m; data_in_slave = s;
        end
        tick();
        read_master = 1'b0; read_slave = 1'b0;
        load_master = 1'b0; load_slave = 1'b0;
        if (exp_m_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=0x%h expected=entry", tag, data_out_master);
        end else begin
            em = exp_m_q.pop_front();
            es = exp_s_q.pop_front();
            check({tag, "_m"}, data_out_master, em);
            check({tag, "_s"}, data_out_slave, es);
        end
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s);
        load_master = 1'b1; load_slave = 1'b1;
        data_in_master = m; data_in_slave = s;
        tick();
        load_master = 1'b0; load_slave = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_out_m", data_out_master, 8'h00);
        check("rst_out_s", data_out_slave, 8'h00);
        reset = 1'b0;
        expect_rd(8'h00, 8'h00);
        do_read("rst_rd");

        // Basic exchange
        load(8'hA5, 8'h3C);
        go();
        expect_rd(8'h3C, 8'hA5);
        tick(16);
        do_read("basic");

        // Double transfer without reload swaps back
        load(8'hFF, 8'h00);
        go();
        tick(16);
        go();
        expect_rd(8'hFF, 8'h00);
        tick(16);
        do_read("double");

        // Load/read ignored mid-transfer
        load(8'h81, 8'h7E);
        expect_rd(8'h81, 8'h7E);
        do_read("pre_ign");
        go();
        expect_rd(8'h7E, 8'h81);
        tick(4);
        load_master = 1'b1; data_in_master = 8'h11; read_master = 1'b1; start = 1'b1;
        tick();
        load_master = 1'b0; read_master = 1'b0; start = 1'b0;
        check("ign_hold5", data_out_master, 8'h81);
        tick(11);
        check("ign_hold_end", data_out_master, 8'h81);
        do_read("ign");

        // Reset mid-transfer aborts
        load(8'hC3, 8'h5A);
        go();
        tick(6);
        reset = 1'b1;
        #1;
        check("abort_out_m", data_out_master, 8'h00);
        check("abort_out_s", data_out_slave, 8'h00);
        tick(2);
        reset = 1'b0;
        expect_rd(8'h00, 8'h00);
        do_read("abort_rd");
        load(8'h12, 8'h34);
        go();
        expect_rd(8'h34, 8'h12);
        tick(16);
        do_read("post_abort");

        // Load together with start
        load_master = 1'b1; load_slave = 1'b1;
        data_in_master = 8'h96; data_in_slave = 8'h69;
        start = 1'b1;
        tick();
        load_master = 1'b0; load_slave = 1'b0; start = 1'b0;
        expect_rd(8'h69, 8'h96);
        tick(16);
        do_read("ld_start");

        // Read with same-cycle load sees pre-load value
        expect_rd(8'h69, 8'h96);
        do_read("rd_ld", 1'b1, 8'h55, 8'hAA);
        expect_rd(8'h55, 8'hAA);
        do_read("after_ld");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_modport.md
SPI_MODPORT -- requirements
Module: spi_modport

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, width of the master and slave shift registers and of all data ports.
REQ-002 SHALL have port: mclk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: load_master  input  1  load data_in_master into the master shift register.
REQ-005 SHALL have port: load_slave  input  1  load data_in_slave into the slave shift register.
REQ-006 SHALL have port: read_master  input  1  copy the master shift register to data_out_master.
REQ-007 SHALL have port: read_slave  input  1  copy the slave shift register to data_out_slave.
REQ-008 SHALL have port: start  input  1  begin one full-duplex transfer.
REQ-009 SHALL have port: data_in_master  input  DATA_WIDTH  parallel load value for the master.
REQ-010 SHALL have port: data_in_slave  input  DATA_WIDTH  parallel load value for the slave.
REQ-011 SHALL have port: data_out_master  output  DATA_WIDTH  registered master read-back.
REQ-012 SHALL have port: data_out_slave  output  DATA_WIDTH  registered slave read-back.
REQ-013 SHALL use exactly one clock (mclk) and an asynchronous active-high reset (reset).

Function
REQ-014 SHALL contain an internal SPI master and SPI slave linked by internal sclk, mosi, miso and ss_n nets (mode 0, MSB first).
REQ-015 SHALL implement FSM states IDLE and XFER, with IDLE following reset.
REQ-016 In IDLE, load_master=1 SHALL set master_sr <= data_in_master at the next edge, and load_slave=1 SHALL set slave_sr <= data_in_slave; the two loads are independent.
REQ-017 In IDLE, start=1 SHALL move the FSM to XFER at the next edge, clear the bit counter, drive ss_n low and keep sclk low.
REQ-018 A load asserted in the same cycle as start SHALL be applied, and the transfer SHALL shift the newly loaded value.
REQ-019 In XFER, each bit SHALL take 2 mclk cycles: sclk rises on the first edge, when both sides sample (master from miso=slave_sr[MSB], slave from mosi=master_sr[MSB]).
REQ-020 On the second edge sclk SHALL fall and both registers SHALL shift left together, with master_sr <= {master_sr[MSB-1:0], slave MSB} and slave_sr <= {slave_sr[MSB-1:0], master MSB}.
REQ-021 After DATA_WIDTH shifts (2*DATA_WIDTH edges after the XFER entry edge), the FSM SHALL return to IDLE and ss_n SHALL go high, so that the master and slave register contents are exchanged.
REQ-022 start, load_master and load_slave SHALL be ignored while in XFER.
REQ-023 In IDLE, read_master=1 SHALL set data_out_master <= master_sr at the next edge, and read_slave=1 SHALL set data_out_slave <= slave_sr.
REQ-024 Reads SHALL be ignored in XFER, and data_out_* SHALL hold their values until the next accepted read.
REQ-025 A read and a load on the same side in the same cycle SHALL capture the pre-load register value.
REQ-026 A start in the same cycle as the final return to IDLE SHALL be ignored.
REQ-027 Back-to-back transfers SHALL be possible from IDLE, and a second transfer without reload SHALL swap the values back.

Reset
REQ-028 While reset=1, the module SHALL set master_sr, slave_sr, data_out_master and data_out_slave to 0, the state to IDLE, the bit counter to 0, sclk low and ss_n high.
REQ-029 A reset asserted mid-transfer SHALL abort the transfer immediately, and no partial data SHALL appear on the data_out_* outputs.
REQ-030 After reset deasserts, the first edge SHALL accept loads and start normally.

Verification
REQ-031 Bench SHALL check reset: reset pulse -> data_out_master=0x00, data_out_slave=0x00 on the next reads.
REQ-032 Bench SHALL check a basic exchange: load master 0xA5 and slave 0x3C, start, wait 16 cycles, read both -> data_out_master=0x3C, data_out_slave=0xA5.
REQ-033 Bench SHALL check a double transfer: 0xFF/0x00, two transfers without reload -> master reads 0xFF, slave reads 0x00.
REQ-034 Bench SHALL check ignored inputs during a transfer: load_master=0x11 and read_master at cycle 5 of a 0x81/0x7E transfer -> load ignored, final master reads 0x7E, and data_out_master stays unchanged until the post-transfer read.
REQ-035 Bench SHALL check an aborted transfer: reset at cycle 7 of a 0xC3/0x5A transfer -> registers 0x00, reads 0x00, then a new 0x12/0x34 transfer yields master 0x34 and slave 0x12.
REQ-036 Bench SHALL check load and start in the same cycle: load 0x96/0x69 with start -> after 16 cycles master reads 0x69 and slave reads 0x96.
